// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state/instruction types, opcode and ALU constants, IR field positions
package cpu_pkg;
  typedef enum logic [2:0] {S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_RD, S_WR_IMM} ctrl_state_t;
  typedef enum logic [2:0] {I_NONE, I_MOV_IMM, I_MOV_REG, I_ADD, I_CMP, I_AND, I_MVN} instr_kind_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;
  localparam int OPC_LSB = 13;
  localparam int OP_LSB = 11;
  localparam int RN_LSB = 8;
  localparam int RD_LSB = 5;
  localparam int SH_LSB = 3;
  localparam int RM_LSB = 0;
  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: splits IR into register/shift fields, sign-extends imm8 and classifies the instruction
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0]  i_ir,
  output instr_kind_t  o_kind,
  output logic [2:0]   o_rn,
  output logic [2:0]   o_rd,
  output logic [2:0]   o_rm,
  output logic [1:0]   o_op,
  output logic [1:0]   o_shift,
  output logic [15:0]  o_sximm8
);
  logic [2:0] w_opc;
  assign w_opc    = i_ir[OPC_LSB +: 3];
  assign o_op     = i_ir[OP_LSB +: 2];
  assign o_rn     = i_ir[RN_LSB +: 3];
  assign o_rd     = i_ir[RD_LSB +: 3];
  assign o_shift  = i_ir[SH_LSB +: 2];
  assign o_rm     = i_ir[RM_LSB +: 3];
  assign o_sximm8 = sext8(i_ir[7:0]);
  // anything outside the six supported opcode/op pairs is I_NONE
  always_comb begin
    o_kind = I_NONE;
    if (w_opc == OPC_MOV)
      o_kind = o_op == OP_MOV_IMM ? I_MOV_IMM : o_op == OP_MOV_REG ? I_MOV_REG : I_NONE;
    else if (w_opc == OPC_ALU)
      case (o_op)
        ALU_ADD: o_kind = I_ADD;
        ALU_SUB: o_kind = I_CMP;
        ALU_AND: o_kind = I_AND;
        ALU_MVN: o_kind = I_MVN;
        default: o_kind = I_NONE;
      endcase
  end
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction register plus Moore control FSM driving the datapath strobes
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [15:0] datapath_in,
  output logic        vsel,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);
  logic [15:0] r_ir;
  ctrl_state_t r_state, w_next;
  instr_kind_t w_kind;
  logic [2:0] w_rn, w_rd, w_rm;
  logic [1:0] w_op, w_shift;
  logic w_unary;
  instr_decoder u_dec (
    .i_ir(r_ir), .o_kind(w_kind), .o_rn(w_rn), .o_rd(w_rd), .o_rm(w_rm),
    .o_op(w_op), .o_shift(w_shift), .o_sximm8(datapath_in)
  );
  assign bsel = 1'b0;
  assign w_unary = w_kind == I_MOV_REG || w_kind == I_MVN;
  // state register; IR only loads while idle so a busy instruction cannot be disturbed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && load) r_ir <= in;
    end
  end
  // next state and Moore outputs; every strobe defaults low and is raised only in its own state
  always_comb begin
    w_next   = S_WAIT;
    w        = 1'b0;
    vsel     = 1'b0;
    writenum = '0;
    readnum  = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    shift    = '0;
    ALUop    = '0;
    case (r_state)
      S_WAIT: begin
        w      = 1'b1;
        w_next = s ? S_DECODE : S_WAIT;
      end
      S_DECODE:
        w_next = w_kind == I_MOV_IMM ? S_WR_IMM :
                 w_unary ? S_GET_B :
                 w_kind == I_NONE ? S_WAIT : S_GET_A;
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = S_GET_B;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_ALU;
      end
      S_ALU: begin
        shift  = w_shift;
        ALUop  = w_kind == I_MOV_REG ? ALU_ADD : w_op;
        asel   = w_unary;
        loadc  = w_kind != I_CMP;
        loads  = w_kind == I_CMP;
        w_next = w_kind == I_CMP ? S_WAIT : S_WR_RD;
      end
      S_WR_RD: begin
        writenum = w_rd;
        write    = 1'b1;
      end
      S_WR_IMM: begin
        vsel     = 1'b1;
        writenum = w_rn;
        write    = 1'b1;
      end
      default: w_next = S_WAIT;
    endcase
  end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: cycle-by-cycle vector table for cpu_ctrl plus latency/write-count sequences
module tb_cpu_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0, load = 1'b0, s = 1'b0;
  logic [15:0] in = '0;
  logic w, vsel, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0] writenum, readnum;
  logic [1:0] shift, ALUop;
  logic [15:0] datapath_in;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .datapath_in(datapath_in), .vsel(vsel), .writenum(writenum), .readnum(readnum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop)
  );

  typedef struct {
    logic        rs, ld, st;
    logic [15:0] din;
    logic [34:0] exp;
  } vec_t;
  vec_t vq[$];

  logic [34:0] act;
  assign act = {w, write, vsel, loada, loadb, loadc, loads, asel, bsel,
                writenum, readnum, shift, ALUop, datapath_in};

  function automatic void add(input logic rs, ld, st, input logic [15:0] din,
                              input logic ew, ewr, evs, ela, elb, elc, els, eas,
                              input logic [2:0] ewn, ern, input logic [1:0] esh, eop,
                              input logic [15:0] edpi);
    vec_t v;
    v.rs = rs; v.ld = ld; v.st = st; v.din = din;
    v.exp = {ew, ewr, evs, ela, elb, elc, els, eas, 1'b0, ewn, ern, esh, eop, edpi};
    vq.push_back(v);
  endfunction

  task automatic run_seq(input logic [15:0] instr, input int exp_cyc, input int exp_wr, input string nm);
    int n = 0, wr = 0;
    load = 1'b1; s = 1'b1; in = instr;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0; in = '0;
    while (!w && n < 20) begin
      n++;
      if (write) wr++;
      if (n == 1) load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
    end
    total++;
    if (n != exp_cyc) begin
      bad++;
      $display("FAIL %s busy cycles: got %0d want %0d", nm, n, exp_cyc);
    end
    total++;
    if (wr != exp_wr) begin
      bad++;
      $display("FAIL %s write pulses: got %0d want %0d", nm, wr, exp_wr);
    end
    total++;
    if (datapath_in !== {{8{instr[7]}}, instr[7:0]}) begin
      bad++;
      $display("FAIL %s IR held: datapath_in got %h want %h", nm, datapath_in, {{8{instr[7]}}, instr[7:0]});
    end
  endtask

  initial begin
    // rs ld st din      w wr vs la lb lc ls as  wn rn sh op  dpi
    add(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 1, 1, 16'hD32A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h002A);
    add(0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 16'h002A);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h002A);
    add(0, 1, 0, 16'hD50D, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h000D);
    add(0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h000D);
    add(0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 16'h000D);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h000D);
    // ADD R2,R5,R3
    add(0, 1, 1, 16'hA543, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0043);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 16'h0043);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 16'h0043);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0043);
    add(0, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 16'h0043);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0043);
    // MOV R1,#-1
    add(0, 1, 1, 16'hD1FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF);
    add(0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'hFFFF);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF);
    // MOV R4,R3,LSL#1
    add(0, 1, 1, 16'hC08B, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFF8B);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 16'hFF8B);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 16'hFF8B);
    add(0, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 16'hFF8B);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFF8B);
    // MVN R6,R2,LSR#1
    add(0, 1, 1, 16'hB8D2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFD2);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 16'hFFD2);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2, 3, 16'hFFD2);
    add(0, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 16'hFFD2);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFD2);
    // CMP R5,R3
    add(0, 1, 1, 16'hAD03, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0003);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 16'h0003);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 16'h0003);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 16'h0003);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0003);
    // AND R3,R2,R1,LSR#1
    add(0, 1, 1, 16'hB271, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0071);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 16'h0071);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0071);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 2, 16'h0071);
    add(0, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 16'h0071);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0071);
    // unsupported opcode 111 and MOV op 01
    add(0, 1, 1, 16'hE000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 1, 1, 16'hC8F0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFF0);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFF0);
    // ADD again: ignored load/s while busy, then reset during GET_B
    add(0, 1, 1, 16'hA543, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0043);
    add(0, 1, 1, 16'hFFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 16'h0043);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 16'h0043);
    add(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    foreach (vq[i]) begin
      reset = vq[i].rs; load = vq[i].ld; s = vq[i].st; in = vq[i].din;
      @(posedge clk); #1;
      total++;
      if (act !== vq[i].exp) begin
        bad++;
        $display("FAIL vec%0d outputs: got %h want %h", i, act, vq[i].exp);
      end
    end
    reset = 1'b0; load = 1'b0; s = 1'b0; in = '0;
    run_seq(16'hA543, 5, 1, "add");
    run_seq(16'hAD03, 4, 0, "cmp");
    run_seq(16'hD32A, 2, 1, "movimm");
    run_seq(16'hC08B, 4, 1, "movreg");
    run_seq(16'hB8D2, 4, 1, "mvn");
    run_seq(16'hE000, 1, 0, "unsup");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Instruction register, decoder and control state machine sitting directly upstream of `datapath`; it drives every datapath control input.
- An instruction word is captured on `load` while idle.
- The block then sequences it over several cycles on `s` by issuing register-read, ALU, status and write-back strobes to `datapath`.
- `w` reports idle/ready to the surrounding CPU top level.

## Interface
Parameters:
- none (widths fixed by the instruction format: 16-bit word, 3-bit register index)

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `in` in 16: instruction word
- `load` in 1: capture `in` into IR (honoured only in WAIT)
- `s` in 1: start execution of IR (honoured only in WAIT)
- `w` out 1: 1 when in WAIT
- `datapath_in` out 16: sign-extended IR[7:0]
- `vsel` out 1: 1 = write-back from `datapath_in`, 0 = from C
- `writenum`, `readnum` out 3: register indices
- `write`, `loada`, `loadb`, `loadc`, `loads` out 1: strobes
- `asel` out 1: 1 = A operand forced to 0
- `bsel` out 1: B operand select, always 0 from this block
- `shift` out 2: IR[4:3] during ALU of register forms, else 0
- `ALUop` out 2: 00 add, 01 sub, 10 and, 11 not-B

## Operation
- Instruction fields:
  - IR[15:13] opcode
  - IR[12:11] op
  - IR[10:8] Rn
  - IR[7:5] Rd
  - IR[4:3] shift
  - IR[2:0] Rm
  - IR[7:0] imm8
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
- States: WAIT, DECODE, GET_A, GET_B, ALU, WR_RD, WR_IMM.
- WAIT:
  - `s`=1 → DECODE, else stay.
  - `load`=1 → IR←`in`.
  - `load` and `s` in the same cycle: DECODE uses the newly loaded IR.
- DECODE transitions:
  - MOV imm → WR_IMM.
  - ADD, CMP, AND → GET_A.
  - MOV reg, MVN → GET_B.
  - Any other opcode/op → WAIT with no strobes.
- Transitions after DECODE:
  - GET_A → GET_B.
  - GET_B → ALU.
  - ALU → WAIT for CMP, else → WR_RD.
  - WR_RD → WAIT.
  - WR_IMM → WAIT.
- Outputs are Moore (state + IR); every strobe is 0 outside its state:
  - WR_IMM: `vsel`=1, `writenum`=Rn, `write`=1.
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - ALU: `shift`=IR[4:3], `bsel`=0.
    - ALUop=op for 101 instructions, 00 for MOV reg.
    - `asel`=1 for MOV reg and MVN, 0 otherwise.
    - `loadc`=1 except CMP, which has `loads`=1 and `loadc`=0.
  - WR_RD: `vsel`=0, `writenum`=Rd, `write`=1.
- Defaults when unused: `readnum`, `writenum`, `shift` and `ALUop` are 0.
- `datapath_in` = {{8{IR[7]}}, IR[7:0]} continuously.
- `load` or `s` outside WAIT: ignored, IR unchanged.

## Timing
- Reset: the cycle after the `reset` edge is in WAIT.
  - IR=0, `w`=1, all strobes 0, `datapath_in`=0.
  - During the cycle `reset` is asserted, outputs still reflect the current state.
- Cycles from the `s` edge until `w` returns to 1 (counting the DECODE cycle):
  - MOV imm: 2
  - MOV reg: 4
  - MVN: 4
  - CMP: 4
  - ADD/AND: 5
  - Unsupported: 1
- Each strobe is high for exactly one cycle.
  - The datapath register it targets updates on the edge ending that cycle.
- Reset mid-instruction: the next state is WAIT, and no `write` is issued after the reset edge.
  - A partially executed instruction leaves already-written registers as they are.

## Structure
- `cpu_pkg`:
  - state enum `ctrl_state_t`
  - opcode constants `OPC_MOV`=3'b110, `OPC_ALU`=3'b101
  - ALUop constants `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_MVN`
  - field-slice localparams
- One sub-module, `instr_decoder`: combinational field extraction, sign extension and instruction classification from IR.
- The FSM and IR live in `cpu_ctrl`.

## Test plan
Each scenario connects `cpu_ctrl` to `datapath`.
- **Reset:** assert `reset` for one cycle → `w`=1, all strobes 0, IR=0.
- **MOV imm:** `in`=16'hD32A (MOV R3,#42), `load`+`s` in one cycle, then `in`=16'hD50D (MOV R5,#13).
  - Each instruction shows `write`=1 with `vsel`=1 for one cycle.
  - `w` returns to 1 two cycles after `s`.
  - Result: R3=42, R5=13.
- **ADD:** `in`=16'hA543 (ADD R2,R5,R3).
  - Strobe sequence: `loada` with `readnum`=5, then `loadb` with `readnum`=3, then `loadc` with ALUop=00, asel=0, then `write` with `writenum`=2.
  - `datapath_out`=55.
  - `w`=1 after 5 cycles.
- **Immediate and shift forms:**
  - `in`=16'hD1FF → `datapath_in`=16'hFFFF, R1=-1.
  - `in`=16'hC08B (MOV R4,R3,LSL#1) → ALU cycle has `asel`=1, `shift`=01; R4=84.
- **CMP:** `in`=16'hAD03 (CMP R5,R3).
  - ALU cycle has `loads`=1, `loadc`=0, ALUop=01.
  - No `write` occurs; `w`=1 after 4 cycles; Z_out=0.
- **Reset/ignored inputs:** start 16'hA543 and assert `reset` during GET_B.
  - Next cycle: WAIT, `w`=1, R2 unchanged.
  - `load` pulsed during a busy state leaves IR unchanged.
